control_unit: RTL and testbench

Instruction decoder for the 5-bit-opcode SimpleRisc-style processor. It sits at the decode stage. It maps each instruction's opcode and immediate bit to one-hot ALU-operation flags and datapath control flags (memory, branch, writeback, immediate select). Outputs are registered: one rising clock edge after an opcode is presented, the decoded flags appear at the outputs for the next pipeline stage.

---
 rtl/control_unit.sv | 177 +++++++++++++++++
 tb/tb_control_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: decode-stage instruction decoder for the 5-bit-opcode
// SimpleRisc-style processor. It turns an opcode and the instruction I bit
// into one-hot ALU-operation flags and datapath control flags. All outputs
// are registered, so the decode appears one rising edge after the opcode is
// presented.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; clears every output
//   opcode[4:0]  instruction bits [31:27]
//   imm          instruction I bit (second operand is the immediate)
//   isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUBranch, isCall
//                datapath control flags
//   isAdd .. isMov
//                one-hot ALU operation select (ld/st reuse isAdd)
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       imm,
  output logic       isSt,
  output logic       isLd,
  output logic       isBeq,
  output logic       isBgt,
  output logic       isRet,
  output logic       isImmediate,
  output logic       isWb,
  output logic       isUBranch,
  output logic       isCall,
  output logic       isAdd,
  output logic       isSub,
  output logic       isCmp,
  output logic       isMul,
  output logic       isDiv,
  output logic       isMod,
  output logic       isLsl,
  output logic       isLsr,
  output logic       isAsr,
  output logic       isOr,
  output logic       isAnd,
  output logic       isNot,
  output logic       isMov
);

  // Opcode map
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  // Bit positions of each flag in the packed control word
  localparam int F_ST   = 0;
  localparam int F_LD   = 1;
  localparam int F_BEQ  = 2;
  localparam int F_BGT  = 3;
  localparam int F_RET  = 4;
  localparam int F_IMM  = 5;
  localparam int F_WB   = 6;
  localparam int F_UBR  = 7;
  localparam int F_CALL = 8;
  localparam int F_ADD  = 9;
  localparam int F_SUB  = 10;
  localparam int F_CMP  = 11;
  localparam int F_MUL  = 12;
  localparam int F_DIV  = 13;
  localparam int F_MOD  = 14;
  localparam int F_LSL  = 15;
  localparam int F_LSR  = 16;
  localparam int F_ASR  = 17;
  localparam int F_OR   = 18;
  localparam int F_AND  = 19;
  localparam int F_NOT  = 20;
  localparam int F_MOV  = 21;
  localparam int NFLAGS = 22;

  logic [NFLAGS-1:0] flags_d;
  logic [NFLAGS-1:0] flags_q;

  // Combinational decode of the presented opcode into the next control word
  always_comb begin
    flags_d = '0;
    case (opcode)
      OP_ADD: begin flags_d[F_ADD] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_SUB: begin flags_d[F_SUB] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_MUL: begin flags_d[F_MUL] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_DIV: begin flags_d[F_DIV] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_MOD: begin flags_d[F_MOD] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      // cmp only sets flags, never writes a register
      OP_CMP: begin flags_d[F_CMP] = 1'b1; flags_d[F_IMM] = imm; end
      OP_AND: begin flags_d[F_AND] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_OR:  begin flags_d[F_OR]  = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_NOT: begin flags_d[F_NOT] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_MOV: begin flags_d[F_MOV] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_LSL: begin flags_d[F_LSL] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_LSR: begin flags_d[F_LSR] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_ASR: begin flags_d[F_ASR] = 1'b1; flags_d[F_WB] = 1'b1; flags_d[F_IMM] = imm; end
      OP_NOP: begin flags_d = '0; end
      // Memory ops compute base + offset on the adder; offset is always immediate
      OP_LD: begin
        flags_d[F_LD]  = 1'b1;
        flags_d[F_ADD] = 1'b1;
        flags_d[F_IMM] = 1'b1;
        flags_d[F_WB]  = 1'b1;
      end
      OP_ST: begin
        flags_d[F_ST]  = 1'b1;
        flags_d[F_ADD] = 1'b1;
        flags_d[F_IMM] = 1'b1;
      end
      OP_BEQ: begin flags_d[F_BEQ] = 1'b1; end
      OP_BGT: begin flags_d[F_BGT] = 1'b1; end
      OP_B:   begin flags_d[F_UBR] = 1'b1; end
      // call writes the return address into the register file
      OP_CALL: begin
        flags_d[F_CALL] = 1'b1;
        flags_d[F_UBR]  = 1'b1;
        flags_d[F_WB]   = 1'b1;
      end
      OP_RET: begin
        flags_d[F_RET] = 1'b1;
        flags_d[F_UBR] = 1'b1;
      end
      // Undefined opcodes behave as nop
      default: begin flags_d = '0; end
    endcase
  end

  // Output register; reset wins over the opcode sampled on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign isSt        = flags_q[F_ST];
  assign isLd        = flags_q[F_LD];
  assign isBeq       = flags_q[F_BEQ];
  assign isBgt       = flags_q[F_BGT];
  assign isRet       = flags_q[F_RET];
  assign isImmediate = flags_q[F_IMM];
  assign isWb        = flags_q[F_WB];
  assign isUBranch   = flags_q[F_UBR];
  assign isCall      = flags_q[F_CALL];
  assign isAdd       = flags_q[F_ADD];
  assign isSub       = flags_q[F_SUB];
  assign isCmp       = flags_q[F_CMP];
  assign isMul       = flags_q[F_MUL];
  assign isDiv       = flags_q[F_DIV];
  assign isMod       = flags_q[F_MOD];
  assign isLsl       = flags_q[F_LSL];
  assign isLsr       = flags_q[F_LSR];
  assign isAsr       = flags_q[F_ASR];
  assign isOr        = flags_q[F_OR];
  assign isAnd       = flags_q[F_AND];
  assign isNot       = flags_q[F_NOT];
  assign isMov       = flags_q[F_MOV];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of directed vectors, a couple
// of hand-written timing sequences, then randomized opcodes/imm/rst checked
// against a rule-based reference decoder.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic       imm;
  logic isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUBranch, isCall;
  logic isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr;
  logic isOr, isAnd, isNot, isMov;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imm(imm),
    .isSt(isSt), .isLd(isLd), .isBeq(isBeq), .isBgt(isBgt), .isRet(isRet),
    .isImmediate(isImmediate), .isWb(isWb), .isUBranch(isUBranch), .isCall(isCall),
    .isAdd(isAdd), .isSub(isSub), .isCmp(isCmp), .isMul(isMul), .isDiv(isDiv),
    .isMod(isMod), .isLsl(isLsl), .isLsr(isLsr), .isAsr(isAsr), .isOr(isOr),
    .isAnd(isAnd), .isNot(isNot), .isMov(isMov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Masks into the bench's view of the outputs (see act below)
  localparam logic [21:0] M_ST   = 22'h000001;
  localparam logic [21:0] M_LD   = 22'h000002;
  localparam logic [21:0] M_BEQ  = 22'h000004;
  localparam logic [21:0] M_BGT  = 22'h000008;
  localparam logic [21:0] M_RET  = 22'h000010;
  localparam logic [21:0] M_IMM  = 22'h000020;
  localparam logic [21:0] M_WB   = 22'h000040;
  localparam logic [21:0] M_UBR  = 22'h000080;
  localparam logic [21:0] M_CALL = 22'h000100;
  localparam logic [21:0] M_ADD  = 22'h000200;
  localparam logic [21:0] M_SUB  = 22'h000400;
  localparam logic [21:0] M_CMP  = 22'h000800;
  localparam logic [21:0] M_MUL  = 22'h001000;
  localparam logic [21:0] M_DIV  = 22'h002000;
  localparam logic [21:0] M_MOD  = 22'h004000;
  localparam logic [21:0] M_LSL  = 22'h008000;
  localparam logic [21:0] M_LSR  = 22'h010000;
  localparam logic [21:0] M_ASR  = 22'h020000;
  localparam logic [21:0] M_OR   = 22'h040000;
  localparam logic [21:0] M_AND  = 22'h080000;
  localparam logic [21:0] M_NOT  = 22'h100000;
  localparam logic [21:0] M_MOV  = 22'h200000;
  localparam logic [21:0] M_ALU  = 22'h3FFE00;

  logic [21:0] act;
  assign act = {isMov, isNot, isAnd, isOr, isAsr, isLsr, isLsl, isMod, isDiv,
                isMul, isCmp, isSub, isAdd, isCall, isUBranch, isWb,
                isImmediate, isRet, isBgt, isBeq, isLd, isSt};

  int tests_run;
  int tests_failed;

  // ALU flag by opcode number for the 13 arithmetic/logic opcodes
  logic [21:0] alu_mask [0:12];

  // Reference decoder built from the instruction-set rules
  function automatic logic [21:0] ref_decode(input logic [4:0] op, input logic im);
    logic [21:0] r;
    int n;
    n = int'(op);
    r = 22'h0;
    if (n <= 12) begin
      r = alu_mask[n];
      if (im) r = r | M_IMM;
      if (n != 5) r = r | M_WB;      // every ALU op except cmp writes back
    end else if (n == 14) r = M_LD | M_ADD | M_IMM | M_WB;
    else if (n == 15) r = M_ST | M_ADD | M_IMM;
    else if (n == 16) r = M_BEQ;
    else if (n == 17) r = M_BGT;
    else if (n == 18) r = M_UBR;
    else if (n == 19) r = M_CALL | M_UBR | M_WB;
    else if (n == 20) r = M_RET | M_UBR;
    return r;
  endfunction

  task automatic check(input string name, input logic [21:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (op=%b imm=%b rst=%b)",
               name, act, exp, opcode, imm, rst);
    end
  endtask

  // Present inputs, clock one edge, sample 1 time unit later
  task automatic step(input logic r, input logic [4:0] op, input logic im);
    rst = r; opcode = op; imm = im;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        r;
    logic [4:0]  op;
    logic        im;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input string n, input logic r, input logic [4:0] op,
                         input logic im, input logic [21:0] e);
    vec_t v;
    v.name = n; v.r = r; v.op = op; v.im = im; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [21:0] held;
    logic [21:0] e;
    tests_run = 0;
    tests_failed = 0;
    alu_mask[0]  = M_ADD; alu_mask[1]  = M_SUB; alu_mask[2]  = M_MUL;
    alu_mask[3]  = M_DIV; alu_mask[4]  = M_MOD; alu_mask[5]  = M_CMP;
    alu_mask[6]  = M_AND; alu_mask[7]  = M_OR;  alu_mask[8]  = M_NOT;
    alu_mask[9]  = M_MOV; alu_mask[10] = M_LSL; alu_mask[11] = M_LSR;
    alu_mask[12] = M_ASR;

    add_vec("reset1",     1'b1, 5'b00000, 1'b0, 22'h0);
    add_vec("reset2",     1'b1, 5'b00000, 1'b0, 22'h0);
    add_vec("release",    1'b0, 5'b00000, 1'b0, M_ADD | M_WB);
    add_vec("add",        1'b0, 5'b00000, 1'b0, M_ADD | M_WB);
    add_vec("sub",        1'b0, 5'b00001, 1'b0, M_SUB | M_WB);
    add_vec("mul",        1'b0, 5'b00010, 1'b0, M_MUL | M_WB);
    add_vec("cmp",        1'b0, 5'b00101, 1'b0, M_CMP);
    add_vec("cmp_imm",    1'b0, 5'b00101, 1'b1, M_CMP | M_IMM);
    add_vec("asr_imm",    1'b0, 5'b01100, 1'b1, M_ASR | M_WB | M_IMM);
    add_vec("add_imm",    1'b0, 5'b00000, 1'b1, M_ADD | M_WB | M_IMM);
    add_vec("beq_imm",    1'b0, 5'b10000, 1'b1, M_BEQ);
    add_vec("st",         1'b0, 5'b01111, 1'b0, M_ST | M_ADD | M_IMM);
    add_vec("ld",         1'b0, 5'b01110, 1'b0, M_LD | M_ADD | M_IMM | M_WB);
    add_vec("beq",        1'b0, 5'b10000, 1'b0, M_BEQ);
    add_vec("bgt",        1'b0, 5'b10001, 1'b0, M_BGT);
    add_vec("b",          1'b0, 5'b10010, 1'b0, M_UBR);
    add_vec("call",       1'b0, 5'b10011, 1'b0, M_CALL | M_UBR | M_WB);
    add_vec("ret",        1'b0, 5'b10100, 1'b1, M_RET | M_UBR);
    add_vec("nop",        1'b0, 5'b01101, 1'b1, 22'h0);
    add_vec("undef11111", 1'b0, 5'b11111, 1'b1, 22'h0);
    add_vec("undef10101", 1'b0, 5'b10101, 1'b0, 22'h0);
    // Back-to-back stream: each decode one cycle late, nothing left over
    add_vec("seq_add",    1'b0, 5'b00000, 1'b0, M_ADD | M_WB);
    add_vec("seq_undef",  1'b0, 5'b11111, 1'b0, 22'h0);
    add_vec("seq_sub",    1'b0, 5'b00001, 1'b0, M_SUB | M_WB);
    add_vec("seq_mul",    1'b0, 5'b00010, 1'b0, M_MUL | M_WB);
    add_vec("seq_beq",    1'b0, 5'b10000, 1'b0, M_BEQ);
    add_vec("seq_st",     1'b0, 5'b01111, 1'b0, M_ST | M_ADD | M_IMM);
    add_vec("seq_ret",    1'b0, 5'b10100, 1'b0, M_RET | M_UBR);
    // Reset mid-stream drops the opcode sampled with it
    add_vec("mid_reset",  1'b1, 5'b10011, 1'b1, 22'h0);
    add_vec("resume",     1'b0, 5'b01001, 1'b1, M_MOV | M_WB | M_IMM);

    rst = 1'b1; opcode = 5'b00000; imm = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].op, vecs[i].im);
      check(vecs[i].name, vecs[i].exp);
    end

    // Inputs changing between edges must not reach the outputs
    step(1'b0, 5'b00011, 1'b0);
    held = M_DIV | M_WB;
    check("div", held);
    opcode = 5'b10011; imm = 1'b1;
    #3;
    check("no_comb_path", held);
    @(posedge clk); #1;
    check("call_after_edge", M_CALL | M_UBR | M_WB);

    // Randomized stream against the reference decoder
    for (int k = 0; k < 400; k++) begin
      logic        r;
      logic [4:0]  op;
      logic        im;
      r  = ($urandom_range(15) == 0);
      op = 5'($urandom_range(31));
      im = 1'($urandom_range(1));
      step(r, op, im);
      e = r ? 22'h0 : ref_decode(op, im);
      check("random", e);
      tests_run++;
      if ($countones(act & M_ALU) > 1) begin
        tests_failed++;
        $display("FAIL alu_onehot: got %h expected at most one ALU flag", act & M_ALU);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
